// File: rtl/seek_g_pipe_pkg.sv
// Shared definitions for the seek_g pipeline: width helpers, default modulus
// and the per-lane input bundle.
package seek_g_pipe_pkg;

  localparam int DEF_DW    = 16;
  localparam int Q_DEFAULT = 3329;

  function automatic int g_width(input int dw);
    return dw + 3;
  endfunction

  function automatic int z_width(input int dw);
    return 2 * dw + 1;
  endfunction

  typedef struct packed {
    logic [DEF_DW-1:0]   c;
    logic [2*DEF_DW+1:0] z;
    logic [DEF_DW-1:0]   e;
    logic [DEF_DW+2:0]   f;
  } lane_in_t;

endpackage

// File: rtl/seek_g_pipe_if.sv
// Beat-level handshake and per-lane data bus of seek_g_pipe.
// The master side drives beats in and accepts results; the slave is the pipeline.
interface seek_g_pipe_if
  import seek_g_pipe_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LANES = 4
) ();

  logic                        clear;
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES*DW-1:0]         c;
  logic [LANES*(2*DW+2)-1:0]   z;
  logic [LANES*DW-1:0]         e;
  logic [LANES*g_width(DW)-1:0] f;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*g_width(DW)-1:0] g;
  logic                        busy;

  modport master (
    output clear, in_valid, c, z, e, f, out_ready,
    input  in_ready, out_valid, g, busy
  );

  modport slave (
    input  clear, in_valid, c, z, e, f, out_ready,
    output in_ready, out_valid, g, busy
  );

endinterface

// File: rtl/seek_g_lane.sv
// One lane of the seek_g datapath: stage registers only, enables come from
// the shared control. Optional modular correction stage under SEEK_G_MODCORR_EN.
module seek_g_lane
  import seek_g_pipe_pkg::*;
#(
  parameter int DW    = 16,
  parameter int C_LSB = DW - 3,
  parameter int E_BIT = DW - 3,
`ifdef SEEK_G_MODCORR_EN
  parameter int Q     = Q_DEFAULT,
`endif
  localparam int GW   = g_width(DW),
  localparam int ZW   = z_width(DW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en1,
  input  logic            en2,
`ifdef SEEK_G_MODCORR_EN
  input  logic            en3,
`endif
  input  logic [DW-1:0]   c,
  input  logic [ZW:0]     z,
  input  logic [DW-1:0]   e,
  input  logic [GW-1:0]   f,
  output logic [GW-1:0]   g
);

  logic [GW-1:0] s_q;
  logic [2:0]    t_q;
  logic [GW-1:0] g2_q;

  // Only z[GW-1:0] survives the mod 2^GW sum; the rest of z, c and e is dropped.
  logic unused_bits;
  assign unused_bits = ^{c, e, z};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      t_q <= '0;
    end else if (en1) begin
      s_q <= f + z[GW-1:0];
      t_q <= 3'(c[C_LSB+1:C_LSB]) + 3'(e[E_BIT]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g2_q <= '0;
    end else if (en2) begin
      g2_q <= s_q - GW'(t_q);
    end
  end

`ifdef SEEK_G_MODCORR_EN
  logic [GW-1:0] g3_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g3_q <= '0;
    end else if (en3) begin
      g3_q <= (g2_q >= GW'(Q)) ? (g2_q - GW'(Q)) : g2_q;
    end
  end

  assign g = g3_q;
`else
  assign g = g2_q;
`endif

endmodule

// File: rtl/seek_g_pipe.sv
// Multi-lane g = f - c_slice + z - e_bit pipeline with one shared valid/ready.
// Define SEEK_G_MODCORR_EN to add a third stage doing a conditional subtract of Q.
module seek_g_pipe
  import seek_g_pipe_pkg::*;
#(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int C_LSB = DW - 3,
  parameter int E_BIT = DW - 3,
  parameter int Q     = Q_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  seek_g_pipe_if.slave bus
);

  localparam int GW = g_width(DW);
  localparam int ZB = 2 * DW + 2;

  logic                  s1_valid;
  logic                  s2_valid;
  logic                  en1;
  logic                  en2;
  logic                  last_valid;
  logic [LANES*GW-1:0]   g_raw;

  // A stage loads when it is empty or the stage after it is moving.
`ifdef SEEK_G_MODCORR_EN
  logic s3_valid;
  logic en3;

  assign en3        = !s3_valid || bus.out_ready;
  assign en2        = !s2_valid || en3;
  assign last_valid = s3_valid;
  assign bus.busy   = s1_valid || s2_valid || s3_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
    end else if (bus.clear) begin
      s3_valid <= 1'b0;
    end else if (en3) begin
      s3_valid <= s2_valid;
    end
  end
`else
  assign en2        = !s2_valid || bus.out_ready;
  assign last_valid = s2_valid;
  assign bus.busy   = s1_valid || s2_valid;
`endif

  assign en1          = !s1_valid || en2;
  assign bus.in_ready = en1 && !bus.clear && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (bus.clear) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (en1) s1_valid <= bus.in_valid;
      if (en2) s2_valid <= s1_valid;
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    seek_g_lane #(
      .DW    (DW),
      .C_LSB (C_LSB),
`ifdef SEEK_G_MODCORR_EN
      .Q     (Q),
`endif
      .E_BIT (E_BIT)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en1   (en1),
      .en2   (en2),
`ifdef SEEK_G_MODCORR_EN
      .en3   (en3),
`endif
      .c     (bus.c[l*DW +: DW]),
      .z     (bus.z[l*ZB +: ZB]),
      .e     (bus.e[l*DW +: DW]),
      .f     (bus.f[l*GW +: GW]),
      .g     (g_raw[l*GW +: GW])
    );
  end

  // Result bus is forced to zero whenever nothing valid is presented.
  assign bus.out_valid = last_valid;
  assign bus.g         = last_valid ? g_raw : '0;

endmodule

// File: doc/seek_g_pipe.md
SEEK_G_PIPE -- requirements
Module: seek_g_pipe

Interface
REQ-001 SHALL have parameter DW, default 16, coefficient width.
REQ-002 SHALL have parameter LANES, default 4, number of independent channels.
REQ-003 SHALL have parameter C_LSB, default DW-3, LSB of the 2-bit c slice.
REQ-004 SHALL have parameter E_BIT, default DW-3, index of the e bit.
REQ-005 SHALL have parameter Q, default 3329, modulus used only by the optional correction stage.
REQ-006 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset: asynchronous, active-low; clock is clk.
- clear  in  1  synchronous pipeline flush.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when high with in_valid.
- c  in  LANES*DW  per-lane c.
- z  in  LANES*(2*DW+2)  per-lane z.
- e  in  LANES*DW  per-lane e.
- f  in  LANES*(DW+3)  per-lane f.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- g  out  LANES*(DW+3)  per-lane result.
- busy  out  1  any stage holds data.

Function
REQ-007 Per lane, g SHALL equal (f - c[C_LSB+1:C_LSB] + z[2*DW:0] - e[E_BIT]) mod 2^(DW+3).
- z bits above 2*DW are ignored.
REQ-008 Stage 1 SHALL register s = (f + z[2*DW:0]) mod 2^(DW+3) and t = c slice + e bit (3 bits); stage 2 SHALL register g = s - t.
REQ-009 Base latency SHALL be 2 cycles from accepted beat to out_valid, with no stall.
REQ-010 Throughput SHALL be one beat per cycle while out_ready is high.
REQ-011 A stage SHALL advance when it is empty or its downstream stage advances.
- in_ready = !s1_valid || s1 advances.
- in_ready MAY depend combinationally on out_ready.
REQ-012 While out_valid=1 and out_ready=0, g and out_valid SHALL hold stable.
- No beat is dropped, duplicated or reordered.
REQ-013 All lanes SHALL share one valid/ready handshake.
REQ-014 clear=1 SHALL, on that edge, invalidate all stages.
- Data on in_valid in the same cycle is discarded.
- in_ready is 0 while clear=1.
REQ-015 busy SHALL be the OR of all stage valid flags.
REQ-016 g SHALL be zero whenever out_valid=0.

Reset
REQ-017 While rst_n=0, all stage valids, out_valid, busy, in_ready and g SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL discard in-flight beats without emitting them.
REQ-019 The first acceptance after reset release SHALL be possible on the first clk edge with rst_n=1.

Configuration
REQ-020 With SEEK_G_MODCORR_EN defined, a stage 3 SHALL output g-Q when g>=Q, else g.
- This is a single conditional subtract.
- Latency becomes 3.
- Handshake rules REQ-011..REQ-016 extend to stage 3.
REQ-021 Without SEEK_G_MODCORR_EN, no stage 3 or comparator SHALL exist, Q SHALL be unused, and latency SHALL be 2.

Structure
REQ-022 A shared package SHALL hold:
- width functions for DW+3 and 2*DW+1.
- the default Q constant.
- the per-lane struct {c,z,e,f}.
REQ-023 Per-lane arithmetic SHALL live in sub-module seek_g_lane, instantiated LANES times.
- seek_g_lane is stage registers only, with enables from the shared control.
REQ-024 The top level SHALL own the single valid/ready control.

Verification (DW=16, LANES=4)
REQ-025 f=100, c=16'h6000, z=50, e=16'h2000, out_ready=1 -> g=146 on cycle 2 after acceptance (cycle 3 with macro).
REQ-026 f=0, z=0, c=16'h2000, e=0 -> g=19'h7FFFF (wrap-around).
- z=34'h3_0000_0001 -> top bits ignored, g=1 with f=c=e=0.
REQ-027 Three back-to-back beats with out_ready=0 for 5 cycles:
- in_ready drops after pipeline fills.
- g holds.
- Releasing out_ready yields all three in order, no loss.
REQ-028 clear pulsed with two beats in flight -> out_valid=0 and busy=0 next cycle; neither beat ever appears.
REQ-029 rst_n pulsed low mid-stream -> all outputs 0 asynchronously; post-reset beat is computed correctly.
REQ-030 Macro on, inputs giving raw g=3400 -> g=71; raw 3328 -> 3328.
- Macro off, raw 3400 -> 3400.
